sar_analog_frontend_model: RTL and testbench

- Synthesizable digital stand-in for the SAR ADC analog front end: sample-and-hold, capacitive DAC settling and comparator.
- Sits on the far side of the SAR register interface. Consumes the SAR trial code and returns the comparator decision.
- Used for loopback BIST and closed-loop RTL verification of the SAR datapath without analog models.
- The analog input is a digital word (VIN_W bits) with EXTRA more LSBs than the DAC, so quantisation behaviour is exercised.

---
 rtl/sar_pkg.sv | 21 ++
 rtl/sar_fe_comparator.sv | 25 ++
 rtl/sar_analog_frontend_model.sv | 136 +++++++++++++
 tb/tb_sar_analog_frontend_model.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// Shared types and width helpers for the SAR front-end model and the SAR register bench.
package sar_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_TRACK   = 3'd1,
      ST_HOLD    = 3'd2,
      ST_SETTLE  = 3'd3,
      ST_COMPARE = 3'd4
   } sar_fe_state_t;

   function automatic int vin_width(input int size, input int extra);
      return size + extra;
   endfunction

   // Two guard bits keep held+offset from wrapping in either direction.
   function automatic int cmp_width(input int size, input int extra);
      return vin_width(size, extra) + 2;
   endfunction

endpackage

// File: rtl/sar_fe_comparator.sv
// Combinational signed compare of the held sample plus offset against the scaled DAC code.
module sar_fe_comparator
   import sar_pkg::*;
#(
   parameter  int SIZE   = 3,
   parameter  int EXTRA  = 2,
   parameter  int OFFSET = 0,
   localparam int VIN_W  = vin_width(SIZE, EXTRA),
   localparam int CMP_W  = cmp_width(SIZE, EXTRA)
) (
   input  logic [VIN_W-1:0] vin_held_i,
   input  logic [SIZE-1:0]  code_i,
   output logic             ge_o
);

   logic signed [CMP_W-1:0] offset_s;
   logic signed [CMP_W-1:0] lhs_s;
   logic signed [CMP_W-1:0] rhs_s;

   assign offset_s = CMP_W'(OFFSET);
   assign lhs_s    = $signed({2'b00, vin_held_i}) + offset_s;
   assign rhs_s    = $signed({2'b00, code_i, {EXTRA{1'b0}}});
   assign ge_o     = (lhs_s >= rhs_s);

endmodule

// File: rtl/sar_analog_frontend_model.sv
// Digital stand-in for the SAR sample-and-hold, DAC settling and comparator.
module sar_analog_frontend_model
   import sar_pkg::*;
#(
   parameter  int SIZE          = 3,
   parameter  int EXTRA         = 2,
   parameter  int ACQ_CYCLES    = 2,
   parameter  int SETTLE_CYCLES = 1,
   parameter  int OFFSET        = 0,
   localparam int VIN_W         = vin_width(SIZE, EXTRA)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [VIN_W-1:0] vin,
   input  logic             sample_req,
   input  logic             release_hold,
   input  logic [SIZE-1:0]  dac_code,
   input  logic             code_strobe,
   output logic             comparator_out,
   output logic             cmp_valid,
   output logic             hold_valid,
   output logic             busy
);

   localparam int ACQ_W = $clog2(ACQ_CYCLES + 1);
   localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [ACQ_W-1:0] ACQ_LOAD = ACQ_W'(ACQ_CYCLES - 1);
   localparam logic [SET_W-1:0] SET_LOAD = SET_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
   localparam sar_fe_state_t STROBE_DEST = (SETTLE_CYCLES == 0) ? ST_COMPARE : ST_SETTLE;

   sar_fe_state_t    state_q, state_d;
   logic [ACQ_W-1:0] acq_cnt_q, acq_cnt_d;
   logic [SET_W-1:0] set_cnt_q, set_cnt_d;
   logic [VIN_W-1:0] vin_held_q, vin_held_d;
   logic [SIZE-1:0]  code_q, code_d;
   logic             cmp_out_q, cmp_valid_q, hold_valid_q, busy_q;
   logic             cmp_ge;

   // Fed with code_d so a zero-settle strobe compares the code captured on the same edge.
   sar_fe_comparator #(
      .SIZE   (SIZE),
      .EXTRA  (EXTRA),
      .OFFSET (OFFSET)
   ) u_cmp (
      .vin_held_i (vin_held_q),
      .code_i     (code_d),
      .ge_o       (cmp_ge)
   );

   always_comb begin
      // NOTE: every variable gets its hold value first, so no path through the case infers a latch.
      state_d    = state_q;
      acq_cnt_d  = acq_cnt_q;
      set_cnt_d  = set_cnt_q;
      vin_held_d = vin_held_q;
      code_d     = code_q;
      unique case (state_q)
         ST_IDLE: begin
            if (sample_req) begin
               state_d   = ST_TRACK;
               acq_cnt_d = ACQ_LOAD;
            end
         end
         ST_TRACK: begin
            vin_held_d = vin;
            if (acq_cnt_q == '0) state_d = ST_HOLD;
            else                 acq_cnt_d = acq_cnt_q - ACQ_W'(1);
         end
         ST_HOLD: begin
            if (release_hold) begin
               state_d = ST_IDLE;
            end else if (sample_req) begin
               state_d   = ST_TRACK;
               acq_cnt_d = ACQ_LOAD;
            end else if (code_strobe) begin
               code_d    = dac_code;
               set_cnt_d = SET_LOAD;
               state_d   = STROBE_DEST;
            end
         end
         ST_SETTLE: begin
            if (release_hold) begin
               state_d = ST_IDLE;
            end else if (code_strobe) begin
               code_d    = dac_code;
               set_cnt_d = SET_LOAD;
            end else if (set_cnt_q == '0) begin
               state_d = ST_COMPARE;
            end else begin
               set_cnt_d = set_cnt_q - SET_W'(1);
            end
         end
         ST_COMPARE: begin
            state_d = ST_HOLD;
            if (code_strobe) begin
               code_d    = dac_code;
               set_cnt_d = SET_LOAD;
               state_d   = STROBE_DEST;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are registered decodes of the next state so they line up with state_q.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         acq_cnt_q    <= '0;
         set_cnt_q    <= '0;
         vin_held_q   <= '0;
         code_q       <= '0;
         cmp_out_q    <= 1'b0;
         cmp_valid_q  <= 1'b0;
         hold_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here so every register samples pre-edge values.
         state_q      <= state_d;
         acq_cnt_q    <= acq_cnt_d;
         set_cnt_q    <= set_cnt_d;
         vin_held_q   <= vin_held_d;
         code_q       <= code_d;
         cmp_valid_q  <= (state_d == ST_COMPARE);
         hold_valid_q <= (state_d inside {ST_HOLD, ST_SETTLE, ST_COMPARE});
         busy_q       <= (state_d inside {ST_TRACK, ST_SETTLE, ST_COMPARE});
         if (state_d == ST_COMPARE) cmp_out_q <= cmp_ge;
      end
   end

   assign comparator_out = cmp_out_q;
   assign cmp_valid      = cmp_valid_q;
   assign hold_valid     = hold_valid_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_sar_analog_frontend_model.sv
// Directed bench: four front-end instances (default, long settle, negative and positive offset) share stimulus.
module tb_sar_analog_frontend_model;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [4:0] vin;
   logic       sample_req, release_hold, code_strobe;
   logic [2:0] dac_code;

   logic d_cmp, d_val, d_hold, d_busy;
   logic s_cmp, s_val, s_hold, s_busy;
   logic n_cmp, n_val, n_hold, n_busy;
   logic p_cmp, p_val, p_hold, p_busy;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   sar_analog_frontend_model u_def (
      .clk(clk), .reset_n(reset_n), .vin(vin), .sample_req(sample_req),
      .release_hold(release_hold), .dac_code(dac_code), .code_strobe(code_strobe),
      .comparator_out(d_cmp), .cmp_valid(d_val), .hold_valid(d_hold), .busy(d_busy));

   sar_analog_frontend_model #(.SETTLE_CYCLES(3)) u_set3 (
      .clk(clk), .reset_n(reset_n), .vin(vin), .sample_req(sample_req),
      .release_hold(release_hold), .dac_code(dac_code), .code_strobe(code_strobe),
      .comparator_out(s_cmp), .cmp_valid(s_val), .hold_valid(s_hold), .busy(s_busy));

   sar_analog_frontend_model #(.OFFSET(-3)) u_neg (
      .clk(clk), .reset_n(reset_n), .vin(vin), .sample_req(sample_req),
      .release_hold(release_hold), .dac_code(dac_code), .code_strobe(code_strobe),
      .comparator_out(n_cmp), .cmp_valid(n_val), .hold_valid(n_hold), .busy(n_busy));

   sar_analog_frontend_model #(.OFFSET(3)) u_pos (
      .clk(clk), .reset_n(reset_n), .vin(vin), .sample_req(sample_req),
      .release_hold(release_hold), .dac_code(dac_code), .code_strobe(code_strobe),
      .comparator_out(p_cmp), .cmp_valid(p_val), .hold_valid(p_hold), .busy(p_busy));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0; sample_req = 1'b0; release_hold = 1'b0;
      code_strobe = 1'b0; dac_code = '0; vin = '0;
      tick(); tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic acquire(input logic [4:0] v);
      vin = v; sample_req = 1'b1;
      tick();
      sample_req = 1'b0;
      tick(); tick();
   endtask

   task automatic strobe(input logic [2:0] c);
      dac_code = c; code_strobe = 1'b1;
      tick();
      code_strobe = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; sample_req = 1'b0; release_hold = 1'b0;
      code_strobe = 1'b0; dac_code = '0; vin = '0;
      #3;
      total_cnt++;
      if ({d_cmp, d_val, d_hold, d_busy, s_cmp, s_val, s_hold, s_busy,
           n_cmp, n_val, n_hold, n_busy, p_cmp, p_val, p_hold, p_busy} !== 16'h0)
         $display("FAIL reset_outputs: got %b/%b/%b/%b expected all zero",
                  {d_cmp, d_val, d_hold, d_busy}, {s_cmp, s_val, s_hold, s_busy},
                  {n_cmp, n_val, n_hold, n_busy}, {p_cmp, p_val, p_hold, p_busy});
      else pass_cnt++;
      tick();
      reset_n = 1'b1;
      dac_code = 3'd4; code_strobe = 1'b1;
      tick(); tick();
      code_strobe = 1'b0;
      total_cnt++;
      if ({d_val, d_hold, d_busy} !== 3'b000)
         $display("FAIL idle_ignores_strobe: got %b expected 000", {d_val, d_hold, d_busy});
      else pass_cnt++;
   endtask

   task automatic test_basic();
      logic [2:0] codes [3];
      logic       exps  [3];
      codes = '{3'd4, 3'd6, 3'd5};
      exps  = '{1'b1, 1'b0, 1'b1};
      do_reset();
      vin = 5'd22; sample_req = 1'b1;
      tick();
      sample_req = 1'b0;
      total_cnt++;
      if ({d_busy, d_hold} !== 2'b10)
         $display("FAIL track_flags: got busy,hold=%b expected 10", {d_busy, d_hold});
      else pass_cnt++;
      tick();
      total_cnt++;
      if (d_hold !== 1'b0) $display("FAIL hold_early: got %b expected 0", d_hold);
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({d_busy, d_hold} !== 2'b01)
         $display("FAIL hold_latency: got busy,hold=%b expected 01", {d_busy, d_hold});
      else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         strobe(codes[i]);
         total_cnt++;
         if ({d_val, d_busy} !== 2'b01)
            $display("FAIL settle_%0d: got val,busy=%b expected 01", i, {d_val, d_busy});
         else pass_cnt++;
         tick();
         total_cnt++;
         if ({d_val, d_cmp} !== {1'b1, exps[i]})
            $display("FAIL compare_code%0d: got val,cmp=%b expected 1%b", codes[i], {d_val, d_cmp}, exps[i]);
         else pass_cnt++;
         tick();
         total_cnt++;
         if ({d_val, d_cmp, d_hold} !== {1'b0, exps[i], 1'b1})
            $display("FAIL after_compare%0d: got val,cmp,hold=%b expected 0%b1", codes[i], {d_val, d_cmp, d_hold}, exps[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      acquire(5'd22);
      strobe(3'd4);
      tick();
      total_cnt++;
      if ({d_val, d_cmp} !== 2'b11) $display("FAIL b2b_first: got %b expected 11", {d_val, d_cmp});
      else pass_cnt++;
      strobe(3'd7);
      total_cnt++;
      if ({d_val, d_busy} !== 2'b01) $display("FAIL b2b_gap: got val,busy=%b expected 01", {d_val, d_busy});
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({d_val, d_cmp} !== 2'b10) $display("FAIL b2b_second: got %b expected 10", {d_val, d_cmp});
      else pass_cnt++;
   endtask

   task automatic test_settle_restart();
      int first  = 0;
      int pulses = 0;
      logic cmp_at = 1'bx;
      do_reset();
      acquire(5'd10);
      strobe(3'd2);
      dac_code = 3'd7; code_strobe = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         code_strobe = 1'b0;
         if (s_val === 1'b1) begin
            pulses++;
            if (first == 0) begin
               first  = k;
               cmp_at = s_cmp;
            end
         end
      end
      total_cnt++;
      if (pulses !== 1) $display("FAIL restart_pulses: got %0d expected 1", pulses);
      else pass_cnt++;
      total_cnt++;
      if (first !== 4) $display("FAIL restart_latency: got %0d expected 4", first);
      else pass_cnt++;
      total_cnt++;
      if (cmp_at !== 1'b0) $display("FAIL restart_latest_code: got %b expected 0", cmp_at);
      else pass_cnt++;
   endtask

   task automatic test_offset();
      do_reset();
      acquire(5'd16);
      strobe(3'd4);
      tick();
      total_cnt++;
      if ({n_val, n_cmp, d_val, d_cmp, p_val, p_cmp} !== 6'b10_11_11)
         $display("FAIL offset_vin16: got neg,def,pos=%b expected 101111", {n_val, n_cmp, d_val, d_cmp, p_val, p_cmp});
      else pass_cnt++;
      do_reset();
      acquire(5'd13);
      strobe(3'd4);
      tick();
      total_cnt++;
      if ({n_val, n_cmp, d_val, d_cmp, p_val, p_cmp} !== 6'b10_10_11)
         $display("FAIL offset_vin13: got neg,def,pos=%b expected 101011", {n_val, n_cmp, d_val, d_cmp, p_val, p_cmp});
      else pass_cnt++;
   endtask

   task automatic test_edges();
      do_reset();
      acquire(5'd0);
      strobe(3'd0);
      tick();
      total_cnt++;
      if ({d_cmp, n_cmp} !== 2'b10)
         $display("FAIL vin0_code0: got def,neg=%b expected 10", {d_cmp, n_cmp});
      else pass_cnt++;
      strobe(3'd1);
      tick();
      total_cnt++;
      if ({d_val, d_cmp} !== 2'b10) $display("FAIL vin0_code1: got %b expected 10", {d_val, d_cmp});
      else pass_cnt++;
      do_reset();
      acquire(5'd31);
      for (int c = 0; c < 8; c++) begin
         strobe(3'(c));
         tick();
         total_cnt++;
         if ({d_val, d_cmp} !== 2'b11) $display("FAIL vin31_code%0d: got %b expected 11", c, {d_val, d_cmp});
         else pass_cnt++;
      end
   endtask

   task automatic test_track_update();
      do_reset();
      vin = 5'd9; sample_req = 1'b1;
      tick();
      sample_req = 1'b0;
      tick();
      vin = 5'd30;
      tick();
      total_cnt++;
      if (d_hold !== 1'b1) $display("FAIL track_hold: got %b expected 1", d_hold);
      else pass_cnt++;
      vin = 5'd0;
      strobe(3'd7);
      tick();
      total_cnt++;
      if ({d_val, d_cmp} !== 2'b11) $display("FAIL last_track_wins: got %b expected 11", {d_val, d_cmp});
      else pass_cnt++;
   endtask

   task automatic test_release();
      int pulses = 0;
      do_reset();
      acquire(5'd22);
      dac_code = 3'd4; code_strobe = 1'b1; release_hold = 1'b1;
      tick();
      release_hold = 1'b0;
      total_cnt++;
      if ({d_hold, d_busy} !== 2'b00) $display("FAIL release_idle: got hold,busy=%b expected 00", {d_hold, d_busy});
      else pass_cnt++;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (d_val === 1'b1) pulses++;
      end
      code_strobe = 1'b0;
      total_cnt++;
      if ({pulses[3:0], d_hold, d_cmp} !== 6'b0) $display("FAIL release_no_pulse: got pulses=%0d hold=%b cmp=%b expected 0/0/0", pulses, d_hold, d_cmp);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int pulses = 0;
      do_reset();
      acquire(5'd22);
      strobe(3'd4);
      tick();
      strobe(3'd4);
      total_cnt++;
      if ({d_cmp, d_val, d_hold, d_busy} !== 4'b1011)
         $display("FAIL pre_reset_settle: got %b expected 1011", {d_cmp, d_val, d_hold, d_busy});
      else pass_cnt++;
      #2 reset_n = 1'b0;
      #1;
      total_cnt++;
      if ({d_cmp, d_val, d_hold, d_busy} !== 4'b0000)
         $display("FAIL async_reset: got %b expected 0000", {d_cmp, d_val, d_hold, d_busy});
      else pass_cnt++;
      tick();
      reset_n = 1'b1;
      dac_code = 3'd4; code_strobe = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (d_val === 1'b1 || d_hold === 1'b1) pulses++;
      end
      code_strobe = 1'b0;
      total_cnt++;
      if (pulses !== 0) $display("FAIL post_reset_ignore: got %0d active cycles expected 0", pulses);
      else pass_cnt++;
      acquire(5'd22);
      strobe(3'd4);
      tick();
      total_cnt++;
      if ({d_val, d_cmp} !== 2'b11) $display("FAIL post_reset_resample: got %b expected 11", {d_val, d_cmp});
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_settle_restart();
      test_offset();
      test_edges();
      test_track_update();
      test_release();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", pass_cnt, total_cnt);
      $fatal(1);
   end

endmodule
